// File: rtl/demux_1t4_stream.sv
// demux_1t4_stream: buffered 1-to-4 valid/ready stream demultiplexer.
// Each input word is routed to the channel chosen by SEL. Every channel has
// its own 2-entry FIFO, so a stalled consumer only back-pressures words
// aimed at its own channel.
module demux_1t4_stream #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic [1:0]       SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] DOUT0,
  output logic [WIDTH-1:0] DOUT1,
  output logic [WIDTH-1:0] DOUT2,
  output logic [WIDTH-1:0] DOUT3,
  output logic             VALID0,
  output logic             VALID1,
  output logic             VALID2,
  output logic             VALID3,
  input  logic             READY0,
  input  logic             READY1,
  input  logic             READY2,
  input  logic             READY3,
  output logic             BUSY
);

  logic [WIDTH-1:0] mem [4][2];
  logic [1:0]       cnt [4];
  logic [3:0]       wr_ptr;
  logic [3:0]       rd_ptr;
  logic [3:0]       valid;
  logic [3:0]       ready_v;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [WIDTH-1:0] head [4];
  logic             in_ready;

  assign ready_v  = {READY3, READY2, READY1, READY0};
  // Only registered occupancy of the selected channel gates acceptance,
  // so a same-cycle pop on a full channel never opens it for a push.
  assign in_ready = (cnt[SEL] != 2'd2);

  // Per-channel push/pop strobes and head-of-FIFO views.
  always_comb begin
    push  = '0;
    pop   = '0;
    valid = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      valid[n] = (cnt[n] != 2'd0);
      push[n]  = IN_VALID && in_ready && (SEL == 2'(n));
      pop[n]   = valid[n] && ready_v[n];
      head[n]  = valid[n] ? mem[n][rd_ptr[n]] : '0;
    end
  end

  // Occupancy and pointer bookkeeping for all four FIFOs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned n = 0; n < 4; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (push[n] && !pop[n]) begin
          cnt[n] <= cnt[n] + 2'd1;
        end else if (pop[n] && !push[n]) begin
          cnt[n] <= cnt[n] - 2'd1;
        end
        if (push[n]) begin
          wr_ptr[n] <= ~wr_ptr[n];
        end
        if (pop[n]) begin
          rd_ptr[n] <= ~rd_ptr[n];
        end
      end
    end
  end

  // FIFO storage; contents are don't-care while empty because DOUTn is masked.
  always_ff @(posedge CLK) begin
    for (int unsigned n = 0; n < 4; n++) begin
      if (push[n]) begin
        mem[n][wr_ptr[n]] <= DIN;
      end
    end
  end

  assign IN_READY = in_ready;
  assign DOUT0    = head[0];
  assign DOUT1    = head[1];
  assign DOUT2    = head[2];
  assign DOUT3    = head[3];
  assign VALID0   = valid[0];
  assign VALID1   = valid[1];
  assign VALID2   = valid[2];
  assign VALID3   = valid[3];
  assign BUSY     = |valid;

endmodule
